countdown_sequencer: RTL and testbench

Game-level controller for the countdown timer. It consumes the one-second tick from the shared seconds-tick generator and drives that generator's turbo input. It holds a 2-digit BCD seconds value, sequences start/pause/expire, applies bonus-time requests, and feeds the score/HUD display and the game FSM.

---
 rtl/countdown_pkg.sv | 36 +++
 rtl/bcd2_next_value.sv | 35 +++
 rtl/countdown_sequencer.sv | 140 ++++++++++++++
 tb/tb_countdown_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the countdown timer and the HUD score block.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } cd_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd2_t;

    // Values above 99 clamp to 99 so the digits can never leave 0..9.
    function automatic bcd2_t bin2bcd2(input logic [7:0] bin);
        logic [7:0] clamped;
        logic [7:0] t;
        logic [7:0] u;
        bcd2_t      res;
        clamped   = (bin > 8'd99) ? 8'd99 : bin;
        t         = clamped / 8'd10;
        u         = clamped % 8'd10;
        res.tens  = t[3:0];
        res.units = u[3:0];
        return res;
    endfunction

    function automatic logic [7:0] bcd2bin(input bcd2_t v);
        return ({4'd0, v.tens} * 8'd10) + {4'd0, v.units};
    endfunction

endpackage

// File: rtl/bcd2_next_value.sv
// Combinational next value for a 2-digit BCD counter: optional decrement (held at 00)
// plus an optional bonus, saturating at MAX_SEC.
module bcd2_next_value
    import countdown_pkg::*;
#(
    parameter int unsigned BONUS_SEC = 5,
    parameter int unsigned MAX_SEC   = 99
) (
    input  bcd2_t value_i,
    input  logic  dec_i,
    input  logic  add_bonus_i,
    output bcd2_t next_o,
    output logic  zero_o
);

    logic [7:0] work;

    // NOTE: blocking assignments in combinational logic; each step reads the previous one.
    always_comb begin
        work = bcd2bin(value_i);
        if (dec_i && (work != 8'd0)) begin
            work = work - 8'd1;
        end
        if (add_bonus_i) begin
            work = work + BONUS_SEC[7:0];
        end
        if (work > MAX_SEC[7:0]) begin
            work = MAX_SEC[7:0];
        end
    end

    assign next_o = bin2bcd2(work);
    assign zero_o = (work == 8'd0);

endmodule

// File: rtl/countdown_sequencer.sv
// Game countdown controller: 2-digit BCD seconds, start/pause/expire sequencing, bonus time.
// Optional HUD blink during the warning window is built when COUNTDOWN_BLINK_EN is defined.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int unsigned START_SEC = 60,
    parameter int unsigned MAX_SEC   = 99,
    parameter int unsigned WARN_SEC  = 10,
    parameter int unsigned BONUS_SEC = 5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_game,
    input  logic       pause_toggle,
    input  logic       bonus_req,
    input  logic       fast_req,
    input  logic       one_sec,
    output logic       turbo,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       running,
    output logic       warning,
    output logic       time_up,
    output logic       expired,
    output logic       display_en
);

    cd_state_t state_q, state_d;
    bcd2_t     value_q, value_d;
    logic      running_q, expired_q, time_up_q, turbo_q;

    logic      nv_dec, nv_add, nv_zero;
    bcd2_t     nv_next;

    function automatic logic in_warn(input cd_state_t st, input bcd2_t v);
        logic [7:0] b;
        b = bcd2bin(v);
        return ((st == RUN) || (st == PAUSE)) && (b != 8'd0) && (b <= WARN_SEC[7:0]);
    endfunction

    // start_game wins over every other same-cycle request.
    assign nv_dec = !start_game && (state_q == RUN) && one_sec;
    assign nv_add = !start_game && ((state_q == RUN) || (state_q == PAUSE)) && bonus_req;

    bcd2_next_value #(
        .BONUS_SEC (BONUS_SEC),
        .MAX_SEC   (MAX_SEC)
    ) u_next (
        .value_i     (value_q),
        .dec_i       (nv_dec),
        .add_bonus_i (nv_add),
        .next_o      (nv_next),
        .zero_o      (nv_zero)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (start_game) begin
            state_d = RUN;
            value_d = bin2bcd2(START_SEC[7:0]);
        end else begin
            case (state_q)
                RUN: begin
                    value_d = nv_next;
                    if (one_sec && nv_zero) begin
                        state_d = EXPIRED;
                    end else if (pause_toggle) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    value_d = nv_next;
                    if (pause_toggle) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            value_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            time_up_q <= 1'b0;
            turbo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
            time_up_q <= (state_d == EXPIRED) && (state_q != EXPIRED);
            turbo_q   <= fast_req && (state_d == RUN);
        end
    end

    assign tens    = value_q.tens;
    assign units   = value_q.units;
    assign running = running_q;
    assign expired = expired_q;
    assign time_up = time_up_q;
    assign turbo   = turbo_q;
    assign warning = in_warn(state_q, value_q);

`ifdef COUNTDOWN_BLINK_EN
    logic blink_q, blink_d;
    logic warn_next;

    // Blink phase follows the next-cycle warning so display_en stays aligned with warning.
    assign warn_next = in_warn(state_d, value_d);

    always_comb begin
        blink_d = blink_q;
        if (start_game || !warn_next) begin
            blink_d = 1'b1;
        end else if (one_sec && ((state_q == RUN) || (state_q == PAUSE))) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign display_en = blink_q;
`else
    assign display_en = 1'b1;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with default parameters (60/99/10/5).
module tb_countdown_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start_game, pause_toggle, bonus_req, fast_req, one_sec;
    logic       turbo, running, warning, time_up, expired, display_en;
    logic [3:0] tens, units;

    int n_vec = 0;
    int n_err = 0;

    countdown_sequencer dut (
        .clk          (clk),
        .resetN       (resetN),
        .start_game   (start_game),
        .pause_toggle (pause_toggle),
        .bonus_req    (bonus_req),
        .fast_req     (fast_req),
        .one_sec      (one_sec),
        .turbo        (turbo),
        .tens         (tens),
        .units        (units),
        .running      (running),
        .warning      (warning),
        .time_up      (time_up),
        .expired      (expired),
        .display_en   (display_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input int t, input int u);
        check({tag, ".tens"}, int'(tens), t);
        check({tag, ".units"}, int'(units), u);
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            one_sec = 1'b1;
            step();
            one_sec = 1'b0;
        end
    endtask

    task automatic do_start();
        start_game = 1'b1;
        step();
        start_game = 1'b0;
    endtask

    int exp_blink[3];

    initial begin
`ifdef COUNTDOWN_BLINK_EN
        exp_blink = '{0, 1, 0};
`else
        exp_blink = '{1, 1, 1};
`endif
        resetN = 1'b1;
        start_game = 1'b0; pause_toggle = 1'b0; bonus_req = 1'b0;
        fast_req = 1'b0; one_sec = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check_val("reset", 0, 0);
        check("reset.running", running, 0);
        check("reset.warning", warning, 0);
        check("reset.time_up", time_up, 0);
        check("reset.expired", expired, 0);
        check("reset.turbo", turbo, 0);
        check("reset.display_en", display_en, 1);
        @(negedge clk);
        resetN = 1'b1;
        step();

        // Idle ignores ticks and pause
        ticks(1);
        check_val("idle_tick", 0, 0);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("idle_pause.running", running, 0);

        do_start();
        check_val("start", 6, 0);
        check("start.running", running, 1);
        check("start.warning", warning, 0);
        check("start.display_en", display_en, 1);

        ticks(49);
        check_val("at11", 1, 1);
        check("at11.warning", warning, 0);
        ticks(1);
        check_val("at10", 1, 0);
        check("at10.warning", warning, 1);
        ticks(1);
        check_val("at09", 0, 9);
        ticks(8);
        check_val("at01", 0, 1);
        check("at01.time_up", time_up, 0);
        ticks(1);
        check_val("expire", 0, 0);
        check("expire.time_up", time_up, 1);
        check("expire.expired", expired, 1);
        check("expire.running", running, 0);
        check("expire.warning", warning, 0);
        step();
        check("expire+1.time_up", time_up, 0);
        check("expire+1.expired", expired, 1);
        one_sec = 1'b1; bonus_req = 1'b1; step(); one_sec = 1'b0; bonus_req = 1'b0;
        check_val("expired_ignore", 0, 0);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("expired_pause.expired", expired, 1);
        check("expired_pause.running", running, 0);

        // start_game beats same-cycle tick, bonus and pause
        start_game = 1'b1; one_sec = 1'b1; bonus_req = 1'b1; pause_toggle = 1'b1;
        step();
        start_game = 1'b0; one_sec = 1'b0; bonus_req = 1'b0; pause_toggle = 1'b0;
        check_val("restart_prio", 6, 0);
        check("restart_prio.running", running, 1);
        check("restart_prio.expired", expired, 0);

        ticks(3);
        check_val("at57", 5, 7);
        bonus_req = 1'b1;
        for (int i = 0; i < 8; i++) step();
        bonus_req = 1'b0;
        check_val("bonus97", 9, 7);
        bonus_req = 1'b1; step(); bonus_req = 1'b0;
        check_val("bonus_sat", 9, 9);
        bonus_req = 1'b1; step(); bonus_req = 1'b0;
        check_val("bonus_sat2", 9, 9);

        // Bonus and tick together at 01: no expiry
        do_start();
        ticks(59);
        check_val("b_at01", 0, 1);
        one_sec = 1'b1; bonus_req = 1'b1; step(); one_sec = 1'b0; bonus_req = 1'b0;
        check_val("bonus_tick", 0, 5);
        check("bonus_tick.time_up", time_up, 0);
        check("bonus_tick.running", running, 1);
        check("bonus_tick.expired", expired, 0);

        // Pause with same-cycle tick
        do_start();
        ticks(40);
        check_val("at20", 2, 0);
        one_sec = 1'b1; pause_toggle = 1'b1; step(); one_sec = 1'b0; pause_toggle = 1'b0;
        check_val("pause_tick", 1, 9);
        check("pause_tick.running", running, 0);
        ticks(1);
        check_val("pause_hold", 1, 9);
        bonus_req = 1'b1; step(); bonus_req = 1'b0;
        check_val("pause_bonus", 2, 4);
        check("pause_bonus.warning", warning, 0);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("resume.running", running, 1);
        check_val("resume", 2, 4);

        // Turbo follows fast_req only while running
        fast_req = 1'b1; step();
        check("turbo_run", turbo, 1);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("turbo_pause", turbo, 0);
        check("turbo_pause.running", running, 0);
        fast_req = 1'b0;
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("turbo_drop", turbo, 0);
        check("turbo_drop.running", running, 1);

        // Asynchronous reset mid-run
        do_start();
        ticks(27);
        check_val("at33", 3, 3);
        fast_req = 1'b1; step();
        check("pre_reset.turbo", turbo, 1);
        #2 resetN = 1'b0;
        #1;
        check_val("mid_reset", 0, 0);
        check("mid_reset.running", running, 0);
        check("mid_reset.turbo", turbo, 0);
        check("mid_reset.time_up", time_up, 0);
        check("mid_reset.expired", expired, 0);
        check("mid_reset.warning", warning, 0);
        check("mid_reset.display_en", display_en, 1);
        fast_req = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        step();
        check("post_reset.running", running, 0);
        check("post_reset.time_up", time_up, 0);

        // HUD blink in the warning window
        do_start();
        ticks(55);
        check_val("at05", 0, 5);
        check("at05.display_en", display_en, 1);
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            check($sformatf("blink%0d", i), display_en, exp_blink[i]);
        end
        check_val("at02", 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
